// File: rtl/jeff_74x181_nibble_sequencer_pkg.sv
// rtl/jeff_74x181_nibble_sequencer_pkg.sv - shared defs for the nibble-serial 74x181 ALU
// State encodings, 74x181 select constants and carry polarity.
package jeff_74x181_nibble_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic [3:0] S_NOT_A             = 4'b0000;
  localparam logic [3:0] S_A_XOR_B           = 4'b0110;
  localparam logic [3:0] S_A_PLUS_B          = 4'b1001;
  localparam logic [3:0] S_A_MINUS_B_MINUS_1 = 4'b0110;
  localparam logic [3:0] S_B                 = 4'b1010;

  localparam logic CARRY_NONE = 1'b1;

endpackage

// File: rtl/jeff_74x181.sv
// rtl/jeff_74x181.sv - combinational 4-bit 74x181 ALU slice, active-high data
// Carry in/out use the chip's active-low polarity; AEQB is the AND of all F bits.
module jeff_74x181 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [3:0] s,
  input  logic       m,
  input  logic       cn,
  output logic [3:0] f,
  output logic       co,
  output logic       aeqb
);

  logic [3:0] p;
  logic [3:0] q;
  logic [4:0] sum;

  // Every arithmetic row of the function table is P + Q + carry; logic rows are XNOR(P, Q).
  assign p    = a | (b & {4{s[0]}}) | (~b & {4{s[1]}});
  assign q    = (a & ~b & {4{s[2]}}) | (a & b & {4{s[3]}});
  assign sum  = {1'b0, p} + {1'b0, q} + {4'b0000, ~cn};
  assign f    = m ? ~(p ^ q) : sum[3:0];
  assign co   = ~sum[4];
  assign aeqb = &f;

endmodule

// File: rtl/jeff_74x181_nibble_sequencer.sv
// rtl/jeff_74x181_nibble_sequencer.sv - WIDTH-bit ALU, one 74x181 nibble per clock, LSB first
// Optional ALU_SEQ_ACCUMULATE_EN adds acc_sel to take operand A from the result register.
module jeff_74x181_nibble_sequencer
  import jeff_74x181_nibble_sequencer_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef ALU_SEQ_ACCUMULATE_EN
  input  logic             acc_sel,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       s,
  input  logic             m,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             aeqb
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
  logic [3:0]       s_q, s_d;
  logic             m_q, m_d;
  logic             carry_q, carry_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             aeqb_acc_q, aeqb_acc_d;
  logic             busy_q, busy_d, done_q, done_d, cout_q, cout_d, aeqb_q, aeqb_d;

  logic [3:0] slice_f;
  logic       slice_co;
  logic       slice_aeqb;

  jeff_74x181 u_slice (
    .a    (a_q[{idx_q, 2'b00} +: 4]),
    .b    (b_q[{idx_q, 2'b00} +: 4]),
    .s    (s_q),
    .m    (m_q),
    .cn   (carry_q),
    .f    (slice_f),
    .co   (slice_co),
    .aeqb (slice_aeqb)
  );

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    s_d        = s_q;
    m_d        = m_q;
    carry_d    = carry_q;
    idx_d      = idx_q;
    aeqb_acc_d = aeqb_acc_q;
    result_d   = result_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    cout_d     = cout_q;
    aeqb_d     = aeqb_q;
    case (state_q)
      IDLE: begin
        if (start) begin
`ifdef ALU_SEQ_ACCUMULATE_EN
          a_d = acc_sel ? result_q : a;
`else
          a_d = a;
`endif
          b_d        = b;
          s_d        = s;
          m_d        = m;
          carry_d    = cin;
          idx_d      = '0;
          aeqb_acc_d = 1'b1;
          busy_d     = 1'b1;
          state_d    = RUN;
        end
      end
      RUN: begin
        // Carry goes straight back into the next nibble: both ends use the chip polarity.
        result_d[{idx_q, 2'b00} +: 4] = slice_f;
        carry_d    = slice_co;
        aeqb_acc_d = aeqb_acc_q & slice_aeqb;
        if (idx_q == IDX_LAST) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        done_d  = 1'b1;
        cout_d  = carry_q;
        aeqb_d  = aeqb_acc_q;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      s_q        <= '0;
      m_q        <= 1'b0;
      carry_q    <= CARRY_NONE;
      idx_q      <= '0;
      aeqb_acc_q <= 1'b0;
      result_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cout_q     <= CARRY_NONE;
      aeqb_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      s_q        <= s_d;
      m_q        <= m_d;
      carry_q    <= carry_d;
      idx_q      <= idx_d;
      aeqb_acc_q <= aeqb_acc_d;
      result_q   <= result_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      cout_q     <= cout_d;
      aeqb_q     <= aeqb_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign cout   = cout_q;
  assign aeqb   = aeqb_q;

endmodule

// File: tb/tb_jeff_74x181_nibble_sequencer.sv
// tb/tb_jeff_74x181_nibble_sequencer.sv - self-checking bench for jeff_74x181_nibble_sequencer
// Reference model evaluates the 74x181 function table on full-width operands.
module tb_jeff_74x181_nibble_sequencer;
  import jeff_74x181_nibble_sequencer_pkg::*;

  localparam int WIDTH   = 16;
  localparam int NIBBLES = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst, start, m, cin;
  logic [WIDTH-1:0] a, b;
  logic [3:0]       s;
  logic             busy, done, cout, aeqb;
  logic [WIDTH-1:0] result;
`ifdef ALU_SEQ_ACCUMULATE_EN
  logic             acc_sel = 1'b0;
`endif

  int errors = 0;
  int checks = 0;
  logic [WIDTH-1:0] model_result = '0;

  always #5 clk = ~clk;

  jeff_74x181_nibble_sequencer #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
`ifdef ALU_SEQ_ACCUMULATE_EN
    .acc_sel(acc_sel),
`endif
    .a      (a),
    .b      (b),
    .s      (s),
    .m      (m),
    .cin    (cin),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
    .aeqb   (aeqb)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns {cout, aeqb, f}; arithmetic rows written as X + Y from the datasheet table.
  function automatic logic [17:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                        input logic [3:0] ms, input logic mm, input logic mci);
    logic [15:0] x, y, lf, f;
    logic [16:0] sum;
    case (ms)
      4'h0: begin x = ma;       y = 16'h0;    lf = ~ma;        end
      4'h1: begin x = ma | mb;  y = 16'h0;    lf = ~(ma | mb); end
      4'h2: begin x = ma | ~mb; y = 16'h0;    lf = ~ma & mb;   end
      4'h3: begin x = 16'hFFFF; y = 16'h0;    lf = 16'h0;      end
      4'h4: begin x = ma;       y = ma & ~mb; lf = ~(ma & mb); end
      4'h5: begin x = ma | mb;  y = ma & ~mb; lf = ~mb;        end
      4'h6: begin x = ma;       y = ~mb;      lf = ma ^ mb;    end
      4'h7: begin x = ma & ~mb; y = 16'hFFFF; lf = ma & ~mb;   end
      4'h8: begin x = ma;       y = ma & mb;  lf = ~ma | mb;   end
      4'h9: begin x = ma;       y = mb;       lf = ~(ma ^ mb); end
      4'hA: begin x = ma | ~mb; y = ma & mb;  lf = mb;         end
      4'hB: begin x = ma & mb;  y = 16'hFFFF; lf = ma & mb;    end
      4'hC: begin x = ma;       y = ma;       lf = 16'hFFFF;   end
      4'hD: begin x = ma | mb;  y = ma;       lf = ma | ~mb;   end
      4'hE: begin x = ma | ~mb; y = ma;       lf = ma | mb;    end
      default: begin x = ma;    y = 16'hFFFF; lf = ma;         end
    endcase
    sum = {1'b0, x} + {1'b0, y} + (mci ? 17'd0 : 17'd1);
    f = mm ? lf : sum[15:0];
    return {~sum[16], (f == 16'hFFFF), f};
  endfunction

  task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                        input logic [3:0] ts, input logic tm, input logic tci, input logic tacc);
    logic [17:0] exp;
    int lat;
    exp = model(tacc ? model_result : ta, tb, ts, tm, tci);
    a = ta; b = tb; s = ts; m = tm; cin = tci; start = 1'b1;
`ifdef ALU_SEQ_ACCUMULATE_EN
    acc_sel = tacc;
`endif
    @(posedge clk); #1;
    start = 1'b0;
    a = 16'($urandom); b = 16'($urandom); s = 4'($urandom); m = 1'($urandom); cin = 1'($urandom);
`ifdef ALU_SEQ_ACCUMULATE_EN
    acc_sel = 1'($urandom);
`endif
    lat = 0;
    while (done !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, lat, NIBBLES + 1);
    check({tag, " result"}, result, exp[15:0]);
    check({tag, " cout"}, cout, exp[17]);
    check({tag, " aeqb"}, aeqb, exp[16]);
    check({tag, " busy at done"}, busy, 0);
    model_result = exp[15:0];
    @(posedge clk); #1;
    check({tag, " done pulse"}, done, 0);
    check({tag, " hold"}, result, exp[15:0]);
  endtask

  initial begin
    logic [17:0] e;
    int n_done, first, second, cnt;

    rst = 1'b1; start = 1'b0; a = '0; b = '0; s = '0; m = 1'b0; cin = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset result", result, 0);
    check("reset cout", cout, 1);
    check("reset aeqb", aeqb, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op("add ripple", 16'h00FF, 16'h0001, S_A_PLUS_B, 1'b0, CARRY_NONE, 1'b0);
    check("add ripple literal", result, 16'h0100);
    run_op("carry out", 16'hFFFF, 16'h0001, S_A_PLUS_B, 1'b0, CARRY_NONE, 1'b0);
    check("carry out literal", {cout, result}, 17'h00000);
    run_op("cmp equal", 16'h1234, 16'h1234, S_A_MINUS_B_MINUS_1, 1'b0, CARRY_NONE, 1'b0);
    check("cmp equal literal", {aeqb, result}, 17'h1FFFF);
    run_op("cmp differ", 16'h1234, 16'h1235, S_A_MINUS_B_MINUS_1, 1'b0, CARRY_NONE, 1'b0);
    check("cmp differ literal", aeqb, 0);
    run_op("xor", 16'hA5A5, 16'h0FF0, S_A_XOR_B, 1'b1, CARRY_NONE, 1'b0);
    check("xor literal", result, 16'hAA55);
    run_op("not a", 16'hA5A5, 16'h0FF0, S_NOT_A, 1'b1, CARRY_NONE, 1'b0);
    check("not a literal", result, 16'h5A5A);
    run_op("pass b carry in", 16'h1111, 16'hBEEF, S_B, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 24; i++) begin
      run_op($sformatf("rand%0d", i), 16'($urandom), 16'($urandom), 4'($urandom),
             1'($urandom), 1'($urandom), 1'b0);
    end

    // start held for 10 cycles: accepts at edges 0 and 6 only
    e = model(16'h0F0F, 16'h0101, S_A_PLUS_B, 1'b0, 1'b0);
    a = 16'h0F0F; b = 16'h0101; s = S_A_PLUS_B; m = 1'b0; cin = 1'b0; start = 1'b1;
    n_done = 0; first = -1; second = -1;
    for (int edge_n = 0; edge_n < 16; edge_n++) begin
      @(posedge clk); #1;
      if (edge_n == 9) start = 1'b0;
      if (done === 1'b1) begin
        n_done++;
        if (first < 0) first = edge_n;
        else if (second < 0) second = edge_n;
      end
    end
    check("held start done count", n_done, 2);
    check("held start first done", first, NIBBLES + 1);
    check("held start second done", second, 2 * NIBBLES + 3);
    check("held start result", result, e[15:0]);
    model_result = e[15:0];

    // start pulse while busy carries new operands that must be ignored
    e = model(16'h1357, 16'h2468, S_A_PLUS_B, 1'b0, 1'b1);
    a = 16'h1357; b = 16'h2468; s = S_A_PLUS_B; m = 1'b0; cin = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    a = 16'hFFFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cnt = 0;
    while (done !== 1'b1 && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    check("busy start ignored result", result, e[15:0]);
    check("busy start ignored cout", cout, e[17]);
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (busy === 1'b1 || done === 1'b1) cnt++;
    end
    check("busy start not queued", cnt, 0);

    // reset while RUN at idx=2 aborts with no done
    a = 16'h4321; b = 16'h1111; s = S_A_PLUS_B; m = 1'b0; cin = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort result", result, 0);
    check("abort cout", cout, 1);
    model_result = '0;
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) cnt++;
    end
    check("abort no done", cnt, 0);
    run_op("after abort", 16'h00FF, 16'h0001, S_A_PLUS_B, 1'b0, CARRY_NONE, 1'b0);
`ifdef ALU_SEQ_ACCUMULATE_EN
    run_op("accumulate", 16'h0000, 16'h0001, S_A_PLUS_B, 1'b0, CARRY_NONE, 1'b1);
    check("accumulate literal", result, 16'h0101);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
